// File: rtl/spi_regs_pkg.sv
// Shared constants and frame layout for the SPI register-file front end.
package spi_regs_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

  // Frame as it sits in the shift register once all 16 bits are in (MSB first on the wire).
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } frame_t;

  // A frame commits only if it is exactly 16 bits, a write, and targets an implemented register.
  function automatic logic frame_commits(frame_t f, logic [CNT_W-1:0] cnt, logic ovf);
    return (cnt == CNT_W'(FRAME_BITS)) && !ovf && f.rw && (f.addr <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with one history flop for rise/fall pulse detection.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the asynchronous input through the chain; history trails the synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Level and single-cycle edge pulses.
  always_comb begin
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only front end driving the five pwm_peripheral configuration registers.
// All SPI pins are sampled in the clk domain; nothing here is clocked by sclk.
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_rise, ncs_rise, ncs_fall, copi_s;
  logic unused_sclk_level, unused_sclk_fall, unused_ncs_level;
  logic unused_copi_rise, unused_copi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (sclk),
    .level_o (unused_sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (unused_sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (ncs),
    .level_o (unused_ncs_level),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (copi),
    .level_o (copi_s),
    .rise_o  (unused_copi_rise),
    .fall_o  (unused_copi_fall)
  );

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  // Set only by a seen ncs fall, so a frame already in flight at reset release is never captured.
  logic                  active_q, active_d;
  logic                  commit;
  frame_t                frame;

  assign frame = frame_t'(shift_q);

  // Frame shifter: start on ncs fall, decide on ncs rise, capture on sclk rise in between.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    active_d = active_q;
    commit   = 1'b0;
    if (ncs_fall) begin
      shift_d  = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      active_d = 1'b1;
    end else if (ncs_rise) begin
      // Decision uses the pre-shift counter; a coincident sclk rise is dropped.
      active_d = 1'b0;
      commit   = active_q && frame_commits(frame, cnt_q, ovf_q);
    end else if (active_q && sclk_rise) begin
      if (cnt_q < CNT_W'(FRAME_BITS)) begin
        shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
        cnt_d   = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Frame shifter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      active_q <= active_d;
    end
  end

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  // Register file next state: only the addressed entry loads on commit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (frame.addr == 7'(i))) begin
        regs_d[i] = frame.data;
      end
    end
  end

  // Register file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY[2:0]];

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI-mode-0 write-only register-file front end that sits directly upstream of `pwm_peripheral`. It receives 16-bit frames from an external controller on three `ui_in` pins and drives the five configuration registers that `pwm_peripheral` consumes. All SPI signals are asynchronous to `clk`. They are synchronised and edge-detected entirely in the `clk` domain; no logic is clocked by SCLK.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser; minimum 2.

Ports:
- `clk`  input  1  system clock; the only clock in the block.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `sclk`  input  1  SPI clock, from `ui_in[0]`; idle low (mode 0).
- `copi`  input  1  SPI data, controller-to-peripheral, from `ui_in[1]`.
- `ncs`  input  1  SPI chip select, active-low, from `ui_in[2]`.
- `en_reg_out_7_0`  output  8  register at address 0x00.
- `en_reg_out_15_8`  output  8  register at address 0x01.
- `en_reg_pwm_7_0`  output  8  register at address 0x02.
- `en_reg_pwm_15_8`  output  8  register at address 0x03.
- `pwm_duty_cycle`  output  8  register at address 0x04.

## Operation
- **Frame format:** 16 bits, MSB first.
  - Bit 15 is R/W: 1 = write, 0 = read.
  - Bits 14:8 are the 7-bit address.
  - Bits 7:0 are the data.
- **Synchronisers:** `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flip-flops. `sclk` and `ncs` feed one further history flop for edge detection.
- **Start of frame:** a synchronised `ncs` falling edge clears the 16-bit shift register, the 5-bit bit counter and the overflow flag.
- **Bit capture:** while synchronised `ncs` is low, each synchronised `sclk` rising edge does the following:
  - If the counter is below 16, shift synchronised `copi` into the LSB and increment the counter.
  - If the counter is already 16, set the overflow flag and do not shift.
- **SCLK edges while `ncs` is high:** ignored.
- **Falling SCLK edges:** unused.
- **Commit, on a synchronised `ncs` rising edge:** write the data byte into the addressed register only if all of the following hold:
  - counter == 16,
  - overflow == 0,
  - bit 15 == 1,
  - address ≤ 0x04.
- **Discarded frames:** everything else is silently discarded and no register changes. This covers reads, addresses 0x05–0x7F, frames shorter than 16 bits and frames longer than 16 bits.
- **Write scope:** exactly one register changes per committed frame; the other four hold.
- **No readback:** there is no COPI→CIPO path.
- **Reset:**
  - `rst_n` low immediately forces all five outputs to 0x00, and clears the shift register, counter, overflow flag and all synchroniser/history flops.
  - A reset asserted mid-frame abandons that frame.
  - After release, capture resumes only at the next `ncs` falling edge. Edges already in flight are not treated as a start.

## Timing
- **Input requirements, measured in `clk` periods:**
  - SCLK high ≥ 3 and SCLK low ≥ 3.
  - COPI stable from ≥ 3 before to ≥ 3 after each SCLK rising edge.
  - `ncs` low ≥ 3 before the first SCLK rise.
  - `ncs` high ≥ 3 after the last SCLK rise.
  - `ncs` high ≥ 4 between frames.
- **Commit latency:** registers update on the (`SYNC_STAGES`+1)th `clk` rising edge after `ncs` high is first sampled. That is the 3rd edge at the default setting, with ±1 cycle of synchroniser uncertainty.
- **Output stability:** outputs are registered and glitch-free. They hold their value between commits.
- **Simultaneous events:** an SCLK rise and an `ncs` rise detected in the same `clk` cycle are a protocol violation. The commit decision uses the counter value before that cycle's shift.

## Structure
- **Package `spi_regs_pkg`:**
  - `FRAME_BITS` = 16.
  - `NUM_REGS` = 5.
  - Address constants `ADDR_EN_OUT_7_0` (0x00) through `ADDR_PWM_DUTY` (0x04).
  - `MAX_ADDR` = 0x04.
- **Sub-module `sync_edge`:** `SYNC_STAGES`-deep synchroniser plus history flop. It outputs the synchronised level, a rise pulse and a fall pulse. Instantiate it three times (`sclk`, `ncs`, `copi`; the `copi` instance uses the level only).
- **Top-level contents:** the frame shifter/counter and a 5-entry register file.

## Test plan
- **Reset:** `rst_n` low for 5 cycles with `ncs`=1 → all five outputs 0x00. Assert reset while outputs are nonzero → outputs go to 0x00 before the next `clk` edge.
- **Basic writes:** frame 0x80F0 → `en_reg_out_7_0`=0xF0 within 3–4 `clk` after `ncs` rises, others unchanged. Frame 0x8480 → `pwm_duty_cycle`=0x80.
- **Rejected frames:**
  - Read frame 0x00AA → no register changes.
  - Frame 0x85FF (address 0x05) → no register changes.
  - Frame 0xFF12 (address 0x7F) → no register changes.
- **Length errors:**
  - 12-bit frame → no change.
  - 17-bit frame 0x81 0x3C plus one extra bit → no change.
  - A valid frame 0x813C immediately after → `en_reg_out_15_8`=0x3C.
- **Reset mid-frame:** pulse reset after 8 bits of 0x82AA. Then send a full frame 0x8355 → `en_reg_pwm_7_0` stays 0x00 and `en_reg_pwm_15_8`=0x55.
- **Back-to-back:** frames 0x8001, 0x8102, 0x8203, 0x8304, 0x8405 with `ncs` high exactly 4 `clk` between them → all registers read 01..05 respectively. Sweep SCLK from clk/8 to clk/64.
